spi_mstr_param: RTL
===================

// Module: spi_mstr_param
// PURPOSE
//  Parametrised SPI master, successor to the fixed 16-bit mode-0 master.
//  - Frame width and SCLK divider are set by parameters.
//  - SPI mode (CPOL/CPHA) is selected per transfer.
//  - One frame per wrt pulse; full-duplex: shifts cmd out on MOSI and captures MISO into rd_data.
//  - Sits between the digital core and off-chip SPI slaves such as the ADC128S.
// PARAMETERS
//  DATA_W    16  bits per frame (>=2)
//  SCLK_DIV  32  clk cycles per SCLK period (even, >=4); half period H = SCLK_DIV/2
// PORTS
//  clk      in   1       system clock; all logic on posedge
//  rst      in   1       synchronous, active-high reset
//  wrt      in   1       start pulse; accepted only while busy=0
//  cmd      in   DATA_W  frame to transmit; latched when wrt is accepted
//  mode     in   2       {CPOL,CPHA}; latched when wrt is accepted
//  MISO     in   1       serial data from slave
//  SS_n     out  1       slave select, active low
//  SCLK     out  1       serial clock
//  MOSI     out  1       serial data to slave; equals shift-register output bit
//  busy     out  1       high from the cycle after wrt is accepted until done
//  done     out  1       one-cycle pulse at end of frame
//  rd_data  out  DATA_W  received frame; updated only in the done cycle, held otherwise
// BEHAVIOUR
//  Reset values: SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rd_data=0, latched mode=0, state=IDLE.
//  FSM states: IDLE -> FRONT -> SHIFT -> BACK -> IDLE.
//  - IDLE: SCLK=latched CPOL. On wrt: load shift reg <= cmd, latch mode.
//    Next cycle: SS_n=0, busy=1, SCLK=new CPOL, go to FRONT.
//  - FRONT: hold SCLK idle for H clks; MOSI already shows the first bit. Then go to SHIFT.
//  - SHIFT: DATA_W SCLK periods; SCLK toggles every H clks (2*DATA_W edges).
//    - Leading edge = first toggle away from CPOL in each period.
//    - CPHA=0: sample MISO on the leading edge; shift on the trailing edge, except the last one.
//    - CPHA=1: shift on the leading edge, except the first one; sample on the trailing edge.
//    - Sample = MISO value seen by the clk edge that toggles SCLK. It enters the shift-reg LSB
//      (MSB-first) or MSB (LSB-first).
//    - After the last edge, SCLK is back at CPOL; go to BACK.
//  - BACK: hold SCLK idle for H clks. In the final cycle: SS_n<=1, busy<=0, done<=1,
//    rd_data<=shift reg. Return to IDLE.
//  - Frame length: SS_n low for exactly (DATA_W+1)*SCLK_DIV clks.
//    done asserts (DATA_W+1)*SCLK_DIV+1 clks after the wrt cycle.
//  - Back-to-back: wrt may be asserted in the done cycle; it is accepted, and SS_n stays high
//    for >=1 clk between frames.
//  - wrt while busy=1: ignored; cmd and mode changes have no effect mid-frame.
//  - rst mid-frame: all outputs return to reset values on the next posedge; no done pulse;
//    rd_data becomes 0.
//  - Divider counter width: $clog2(SCLK_DIV). Bit counter width: $clog2(DATA_W+1); it never wraps.
// CONFIGURATION
//  SPI_MSTR_LSB_FIRST_EN defined:
//    - transmit cmd[0] first; received bits fill from the MSB down.
//    - rd_data bit i = i-th bit received.
//  Undefined (default):
//    - MSB first; cmd[DATA_W-1] goes out first.
//    - The first received bit ends in rd_data[DATA_W-1].
// TESTING
//  1 Loopback MOSI->MISO, DATA_W=16, SCLK_DIV=32, mode=0, cmd=16'hA5C3 -> rd_data=16'hA5C3;
//    done 545 clks after wrt; SS_n low 544 clks; 32 SCLK edges.
//  2 Loopback, mode=3, cmd=16'h0F0F -> SCLK idle 1 before and after the frame;
//    rd_data=16'h0F0F; MOSI changes only on falling SCLK edges.
//  3 ADC128S model, mode=0, cmd=16'h2800 twice -> rd_data=16'h0C00, then 16'h0C05;
//    cmd=16'h2000 -> 16'h0BF5.
//  4 Second wrt with cmd=16'hFFFF at clk 100 of a frame carrying cmd=16'h1234 (loopback)
//    -> ignored; rd_data=16'h1234; exactly one done.
//  5 rst=1 at clk 200 of a frame -> next posedge: SS_n=1, SCLK=0, busy=0, rd_data=0;
//    no done pulse; a new wrt then completes normally.
//  6 DATA_W=8, SCLK_DIV=4, SPI_MSTR_LSB_FIRST_EN, loopback, cmd=8'h3C
//    -> MOSI bits 0,0,1,1,1,1,0,0; rd_data=8'h3C; done 37 clks after wrt.

Source files
------------

// File: rtl/spi_mstr_param_if.sv
// Host and SPI-pin bundle for spi_mstr_param.
//   master modport (the SPI master's view):
//     in : wrt (start pulse), cmd[DATA_W] (tx frame), mode[2] {CPOL,CPHA}, MISO
//     out: busy, done (1-cycle end-of-frame pulse), rd_data[DATA_W], SS_n, SCLK, MOSI
//   slave modport: the same signals with directions reversed (host core / bench side).
interface spi_mstr_param_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              wrt;
    logic [DATA_W-1:0] cmd;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  wrt, cmd, mode, MISO,
        output busy, done, rd_data, SS_n, SCLK, MOSI
    );

    modport slave (
        output wrt, cmd, mode, MISO,
        input  busy, done, rd_data, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/spi_mstr_param.sv
// Parametrised full-duplex SPI master: one DATA_W-bit frame per accepted wrt,
// SCLK period SCLK_DIV clks, SPI mode {CPOL,CPHA} latched per transfer.
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   bus        spi_mstr_param_if.master: wrt/cmd/mode in, busy/done/rd_data out,
//              SS_n/SCLK/MOSI out, MISO in
// Build option: define SPI_MSTR_LSB_FIRST_EN to send cmd[0] first and fill received
// bits from the MSB down (rd_data[i] = i-th received bit). Default is MSB first.
module spi_mstr_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic              clk,
    input  logic              rst,
    spi_mstr_param_if.master  bus
);

    localparam int unsigned HALF  = SCLK_DIV / 2;
    localparam int unsigned DIV_W = $clog2(SCLK_DIV);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] BIT_FIRST = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [CNT_W-1:0]  bit_q,     bit_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        mode_q,    mode_d;
    logic              smpl_q,    smpl_d;
    logic              ss_n_q,    ss_n_d;
    logic              sclk_q,    sclk_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    logic              half_end_c;
    logic              leading_c;
    logic [DATA_W-1:0] shift_in_c;
    logic              mosi_c;

    // Shift register advanced by one bit with the held sample entering at the far end.
    // The last sample never enters the register; it is merged when rd_data is loaded.
`ifdef SPI_MSTR_LSB_FIRST_EN
    assign shift_in_c = {smpl_q, shift_q[DATA_W-1:1]};
    assign mosi_c     = shift_q[0];
`else
    assign shift_in_c = {shift_q[DATA_W-2:0], smpl_q};
    assign mosi_c     = shift_q[DATA_W-1];
`endif

    assign half_end_c = (div_q == HALF_LAST);
    // SCLK still at idle level means the coming toggle is the leading edge
    assign leading_c  = (sclk_q == mode_q[1]);

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rd_data_d = rd_data_q;
        mode_d    = mode_q;
        smpl_d    = smpl_q;
        ss_n_d    = ss_n_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = mode_q[1];
                if (bus.wrt) begin
                    shift_d = bus.cmd;
                    mode_d  = bus.mode;
                    sclk_d  = bus.mode[1];
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = FRONT;
                end
            end

            FRONT: begin
                if (half_end_c) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (half_end_c) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (leading_c) begin
                        if (!mode_q[0]) begin
                            smpl_d = bus.MISO;
                        end else if (bit_q != BIT_FIRST) begin
                            shift_d = shift_in_c;
                        end
                    end else begin
                        if (mode_q[0]) begin
                            smpl_d = bus.MISO;
                        end else if (bit_q != BIT_LAST) begin
                            shift_d = shift_in_c;
                        end
                        // Trailing edge closes one SCLK period
                        bit_d = bit_q + CNT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = BACK;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            BACK: begin
                if (half_end_c) begin
                    div_d     = '0;
                    ss_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rd_data_d = shift_in_c;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rd_data_q <= '0;
            mode_q    <= 2'b00;
            smpl_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rd_data_q <= rd_data_d;
            mode_q    <= mode_d;
            smpl_q    <= smpl_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.SS_n    = ss_n_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_c;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_data_q;

endmodule
